// File: rtl/match_sequencer_if.sv
// Control bundle between the pong match sequencer and the game datapath.
// The slave side is the sequencer; the master side is whatever drives frames, keys and scores.
interface match_sequencer_if #(
    parameter int MAX_SCORE_W = 4,
    parameter int CNT_W       = 9
);
    logic                   new_frame_i;
    logic                   start_key_i;
    logic                   pause_key_i;
    logic                   point_player_i;
    logic                   point_enemy_i;
    logic [MAX_SCORE_W-1:0] player_score_i;
    logic [MAX_SCORE_W-1:0] enemy_score_i;
    logic [2:0]             state_o;
    logic                   game_en_o;
    logic                   ball_hold_o;
    logic                   ball_launch_o;
    logic                   score_clear_o;
    logic                   serve_dir_o;
    logic                   winner_o;
    logic [CNT_W-1:0]       countdown_o;

    modport master (
        output new_frame_i, start_key_i, pause_key_i, point_player_i, point_enemy_i,
               player_score_i, enemy_score_i,
        input  state_o, game_en_o, ball_hold_o, ball_launch_o, score_clear_o,
               serve_dir_o, winner_o, countdown_o
    );

    modport slave (
        input  new_frame_i, start_key_i, pause_key_i, point_player_i, point_enemy_i,
               player_score_i, enemy_score_i,
        output state_o, game_en_o, ball_hold_o, ball_launch_o, score_clear_o,
               serve_dir_o, winner_o, countdown_o
    );
endinterface

// File: rtl/match_sequencer.sv
// Round controller for pong: walks a match through idle, serve, play, point, pause and game over,
// gating the datapath with registered enable/hold/launch/clear controls.
module match_sequencer #(
    parameter int MAX_SCORE_W        = 4,
    parameter int WIN_SCORE          = 10,
    parameter int SERVE_DELAY_FRAMES = 90,
    parameter int POINT_DELAY_FRAMES = 60,
    parameter int GAMEOVER_FRAMES    = 300,
    parameter int CNT_W = $clog2((SERVE_DELAY_FRAMES > POINT_DELAY_FRAMES
                          ? (SERVE_DELAY_FRAMES > GAMEOVER_FRAMES ? SERVE_DELAY_FRAMES : GAMEOVER_FRAMES)
                          : (POINT_DELAY_FRAMES > GAMEOVER_FRAMES ? POINT_DELAY_FRAMES : GAMEOVER_FRAMES)) + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    match_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        PAUSE = 3'd4,
        OVER  = 3'd5
    } state_t;

    localparam logic [MAX_SCORE_W-1:0] WIN       = MAX_SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]       ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0]       SERVE_CNT = CNT_W'(SERVE_DELAY_FRAMES);
    localparam logic [CNT_W-1:0]       POINT_CNT = CNT_W'(POINT_DELAY_FRAMES);
    localparam logic [CNT_W-1:0]       OVER_CNT  = CNT_W'(GAMEOVER_FRAMES);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             game_en;
    logic             ball_hold;
    logic             ball_launch;
    logic             score_clear;
    logic             serve_dir;
    logic             winner;
    logic             start_prev;
    logic             pause_prev;
    logic             start_edge;
    logic             pause_edge;

    // {game_en, ball_hold} as seen once the FSM has settled in state s
    function automatic logic [1:0] levels(input state_t s);
        return {s == PLAY, !(s == PLAY || s == PAUSE)};
    endfunction

    // Key edges are registered, so a key press is acted on one cycle after it is seen.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            count       <= '0;
            game_en     <= 1'b0;
            ball_hold   <= 1'b1;
            ball_launch <= 1'b0;
            score_clear <= 1'b0;
            serve_dir   <= 1'b0;
            winner      <= 1'b0;
            start_prev  <= 1'b1;
            pause_prev  <= 1'b1;
            start_edge  <= 1'b0;
            pause_edge  <= 1'b0;
        end else begin
            start_prev  <= bus.start_key_i;
            pause_prev  <= bus.pause_key_i;
            start_edge  <= bus.start_key_i & ~start_prev;
            pause_edge  <= bus.pause_key_i & ~pause_prev;
            ball_launch <= 1'b0;
            score_clear <= 1'b0;

            if (start_edge) begin
                state                  <= SERVE;
                {game_en, ball_hold}   <= levels(SERVE);
                score_clear            <= 1'b1;
                serve_dir              <= 1'b0;
                count                  <= SERVE_CNT;
            end else begin
                case (state)
                    SERVE: if (bus.new_frame_i) begin
                        if (count == ONE) begin
                            state                <= PLAY;
                            {game_en, ball_hold} <= levels(PLAY);
                            ball_launch          <= 1'b1;
                            count                <= '0;
                        end else begin
                            count <= count - ONE;
                        end
                    end
                    // The serve goes toward whoever just lost the point.
                    PLAY: if (bus.point_player_i || bus.point_enemy_i) begin
                        state                <= POINT;
                        {game_en, ball_hold} <= levels(POINT);
                        serve_dir            <= bus.point_player_i;
                        count                <= POINT_CNT;
                    end else if (pause_edge) begin
                        state                <= PAUSE;
                        {game_en, ball_hold} <= levels(PAUSE);
                    end
                    PAUSE: if (pause_edge) begin
                        state                <= PLAY;
                        {game_en, ball_hold} <= levels(PLAY);
                    end
                    POINT: if (bus.new_frame_i) begin
                        if (count == ONE) begin
                            if (bus.player_score_i >= WIN || bus.enemy_score_i >= WIN) begin
                                state                <= OVER;
                                {game_en, ball_hold} <= levels(OVER);
                                winner               <= !(bus.player_score_i >= WIN);
                                count                <= OVER_CNT;
                            end else begin
                                state                <= SERVE;
                                {game_en, ball_hold} <= levels(SERVE);
                                count                <= SERVE_CNT;
                            end
                        end else begin
                            count <= count - ONE;
                        end
                    end
                    OVER: if (bus.new_frame_i) begin
                        if (count == ONE) begin
                            state                <= IDLE;
                            {game_en, ball_hold} <= levels(IDLE);
                            count                <= '0;
                        end else begin
                            count <= count - ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.state_o       = state;
    assign bus.game_en_o     = game_en;
    assign bus.ball_hold_o   = ball_hold;
    assign bus.ball_launch_o = ball_launch;
    assign bus.score_clear_o = score_clear;
    assign bus.serve_dir_o   = serve_dir;
    assign bus.winner_o      = winner;
    assign bus.countdown_o   = count;

endmodule

// File: tb/tb_match_sequencer.sv
// Cycle-by-cycle vector bench for match_sequencer with small delays (win 3, serve 3, point 2, over 4),
// followed by a bounded serve-length sequence.
module tb_match_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    match_sequencer_if #(.MAX_SCORE_W(4), .CNT_W(3)) bus ();

    match_sequencer #(
        .MAX_SCORE_W(4), .WIN_SCORE(3), .SERVE_DELAY_FRAMES(3),
        .POINT_DELAY_FRAMES(2), .GAMEOVER_FRAMES(4), .CNT_W(3)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct packed {
        logic       rst;
        logic       frame;
        logic       start;
        logic       pause;
        logic       pp;
        logic       pe;
        logic [3:0] ps;
        logic [3:0] es;
        logic [2:0] st;
        logic       en;
        logic       hold;
        logic       launch;
        logic       clear;
        logic       dir;
        logic       win;
        logic [2:0] cd;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic add(input logic r, fr, sk, pk, pp, pe, input logic [3:0] ps, es,
                       input logic [2:0] st, input logic en, ho, la, cl, di, wi,
                       input logic [2:0] cd);
        vec_t v;
        v = '{r, fr, sk, pk, pp, pe, ps, es, st, en, ho, la, cl, di, wi, cd};
        vecs.push_back(v);
    endtask

    // Inputs are driven 1 time unit after a rising edge and outputs sampled 1 unit after the next.
    task automatic applyStimulus(input vec_t v);
        rst                = v.rst;
        bus.new_frame_i    = v.frame;
        bus.start_key_i    = v.start;
        bus.pause_key_i    = v.pause;
        bus.point_player_i = v.pp;
        bus.point_enemy_i  = v.pe;
        bus.player_score_i = v.ps;
        bus.enemy_score_i  = v.es;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        logic [11:0] got, exp;
        got = {bus.state_o, bus.game_en_o, bus.ball_hold_o, bus.ball_launch_o,
               bus.score_clear_o, bus.serve_dir_o, bus.winner_o, bus.countdown_o};
        exp = {v.st, v.en, v.hold, v.launch, v.clear, v.dir, v.win, v.cd};
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL vec%0d: got st=%0d en=%b hold=%b launch=%b clear=%b dir=%b win=%b cd=%0d, expected st=%0d en=%b hold=%b launch=%b clear=%b dir=%b win=%b cd=%0d",
                     idx, got[11:9], got[8], got[7], got[6], got[5], got[4], got[3], got[2:0],
                     v.st, v.en, v.hold, v.launch, v.clear, v.dir, v.win, v.cd);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        int n;
        bus.new_frame_i    = 1'b0;
        bus.start_key_i    = 1'b0;
        bus.pause_key_i    = 1'b0;
        bus.point_player_i = 1'b0;
        bus.point_enemy_i  = 1'b0;
        bus.player_score_i = '0;
        bus.enemy_score_i  = '0;

        // rst fr st pa pp pe ps es | st en ho la cl di wi cd
        add(1,0,0,0,0,0,0,0, 0,0,1,0,0,0,0,0);
        add(0,0,0,0,0,0,0,0, 0,0,1,0,0,0,0,0);
        add(0,0,1,0,0,0,0,0, 0,0,1,0,0,0,0,0);
        add(0,0,1,0,0,0,0,0, 1,0,1,0,1,0,0,3);
        add(0,0,0,0,0,0,0,0, 1,0,1,0,0,0,0,3);
        add(0,1,0,0,0,0,0,0, 1,0,1,0,0,0,0,2);
        add(0,0,0,0,0,0,0,0, 1,0,1,0,0,0,0,2);
        add(0,1,0,0,0,0,0,0, 1,0,1,0,0,0,0,1);
        add(0,1,0,0,0,0,0,0, 2,1,0,1,0,0,0,0);
        add(0,0,0,0,0,0,0,0, 2,1,0,0,0,0,0,0);
        add(0,0,0,0,0,1,0,1, 3,0,1,0,0,0,0,2);
        add(0,1,0,0,0,0,3,0, 3,0,1,0,0,0,0,1);
        add(0,1,0,0,0,0,0,1, 1,0,1,0,0,0,0,3);
        add(0,1,0,0,0,0,0,1, 1,0,1,0,0,0,0,2);
        add(0,1,0,0,0,0,0,1, 1,0,1,0,0,0,0,1);
        add(0,1,0,0,0,0,0,1, 2,1,0,1,0,0,0,0);
        add(0,0,0,0,1,1,0,1, 3,0,1,0,0,1,0,2);
        add(0,0,0,0,0,1,1,1, 3,0,1,0,0,1,0,2);
        add(0,1,0,0,0,0,1,1, 3,0,1,0,0,1,0,1);
        add(0,1,0,0,0,0,1,1, 1,0,1,0,0,1,0,3);
        add(0,1,0,0,0,0,1,1, 1,0,1,0,0,1,0,2);
        add(0,1,0,0,0,0,1,1, 1,0,1,0,0,1,0,1);
        add(0,1,0,0,0,0,1,1, 2,1,0,1,0,1,0,0);
        add(0,0,0,1,0,0,1,1, 2,1,0,0,0,1,0,0);
        add(0,0,0,1,0,0,1,1, 4,0,0,0,0,1,0,0);
        add(0,0,0,0,1,0,1,1, 4,0,0,0,0,1,0,0);
        add(0,0,0,1,0,0,1,1, 4,0,0,0,0,1,0,0);
        add(0,0,0,0,0,0,1,1, 2,1,0,0,0,1,0,0);
        add(0,0,0,0,1,0,2,1, 3,0,1,0,0,1,0,2);
        add(0,1,0,0,0,0,2,1, 3,0,1,0,0,1,0,1);
        add(0,1,0,0,0,0,3,1, 5,0,1,0,0,1,0,4);
        add(0,1,0,1,0,0,3,1, 5,0,1,0,0,1,0,3);
        add(0,1,0,0,0,0,3,1, 5,0,1,0,0,1,0,2);
        add(0,1,0,0,0,0,3,1, 5,0,1,0,0,1,0,1);
        add(0,1,0,0,0,0,3,1, 0,0,1,0,0,1,0,0);
        add(0,0,0,0,0,0,3,1, 0,0,1,0,0,1,0,0);
        add(0,0,1,0,0,0,0,0, 0,0,1,0,0,1,0,0);
        add(0,0,0,0,0,0,0,0, 1,0,1,0,1,0,0,3);
        add(0,1,0,0,0,0,0,0, 1,0,1,0,0,0,0,2);
        add(0,1,0,0,0,0,0,0, 1,0,1,0,0,0,0,1);
        add(0,1,0,0,0,0,0,0, 2,1,0,1,0,0,0,0);
        add(0,0,0,0,0,1,2,3, 3,0,1,0,0,0,0,2);
        add(0,1,0,0,0,0,2,3, 3,0,1,0,0,0,0,1);
        add(0,1,0,0,0,0,2,3, 5,0,1,0,0,0,1,4);
        add(0,1,1,0,0,0,2,3, 5,0,1,0,0,0,1,3);
        add(0,1,0,0,0,0,0,0, 1,0,1,0,1,0,1,3);
        add(0,1,0,0,0,0,0,0, 1,0,1,0,0,0,1,2);
        add(0,1,0,0,0,0,0,0, 1,0,1,0,0,0,1,1);
        add(0,1,0,0,0,0,0,0, 2,1,0,1,0,0,1,0);
        add(0,0,0,0,1,0,0,0, 3,0,1,0,0,1,1,2);
        add(0,0,1,0,0,0,0,0, 3,0,1,0,0,1,1,2);
        add(0,1,0,0,0,0,0,0, 1,0,1,0,1,0,1,3);
        add(0,1,0,0,0,0,0,0, 1,0,1,0,0,0,1,2);
        add(0,1,0,0,0,0,0,0, 1,0,1,0,0,0,1,1);
        add(0,1,0,0,0,0,0,0, 2,1,0,1,0,0,1,0);
        add(1,0,1,0,0,0,0,0, 0,0,1,0,0,0,0,0);
        add(0,0,1,0,0,0,0,0, 0,0,1,0,0,0,0,0);
        add(0,0,1,0,0,0,0,0, 0,0,1,0,0,0,0,0);
        add(0,0,0,0,0,0,0,0, 0,0,1,0,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Start a match from IDLE and count frames until launch, bounded to 20 cycles.
        bus.start_key_i = 1'b1;
        @(posedge clk); #1;
        bus.start_key_i = 1'b0;
        @(posedge clk); #1;
        checkValue("serve_entry_clear", int'({bus.state_o, bus.score_clear_o}), int'({3'd1, 1'b1}));
        n = 0;
        bus.new_frame_i = 1'b1;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (bus.ball_launch_o) break;
        end
        bus.new_frame_i = 1'b0;
        checkValue("serve_frames", n, 3);
        checkValue("launch_state", int'(bus.state_o), 2);
        @(posedge clk); #1;
        checkValue("launch_width", int'({bus.ball_launch_o, bus.game_en_o}), int'({1'b0, 1'b1}));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
